frog_scene_renderer: RTL and testbench

Pixel-colour source for the Frogger VGA path; sits directly upstream of the VGA driver and feeds its 8-bit RRRGGGBB `color_in` from the driver's `next_x` / `next_y`. It owns all game state:
- frog position on a 20×15 grid of 32×32 tiles
- four car lanes that advance once per frame
- button handling, collision and the score counter

All state updates happen in vertical blanking, so a drawn frame never tears.

---
 rtl/frog_scene_renderer.sv | 166 ++++++++++++++++
 tb/tb_frog_scene_renderer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/frog_scene_renderer.sv
// Frogger pixel source: owns frog, car lanes, buttons and score, and turns the
// VGA driver's next_x/next_y into a registered RRRGGGBB colour.
module frog_scene_renderer #(
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int CAR_W    = 64
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [9:0] next_x,
    input  logic [9:0] next_y,
    input  logic [3:0] btn_n,
    output logic [7:0] color_in,
    output logic [7:0] score,
    output logic       frame_tick
);

    localparam logic [7:0] YELLOW = 8'b11111100;
    localparam logic [7:0] RED    = 8'b11100000;
    localparam logic [7:0] GREEN  = 8'b00011100;
    localparam logic [7:0] GREY   = 8'b01001001;

    localparam logic [4:0] START_X = 5'd10;
    localparam logic [3:0] START_Y = 4'd14;
    localparam logic [4:0] MAX_X   = 5'd19;
    localparam logic [3:0] MAX_Y   = 4'd14;

    localparam logic [3:0] LANE_ROW [4] = '{4'd3, 4'd6, 4'd9, 4'd12};
    localparam logic [9:0] LANE_X0  [4] = '{10'd0, 10'd160, 10'd320, 10'd480};
    localparam logic [9:0] LANE_SPD [4] = '{10'd1, 10'd2, 10'd3, 10'd4};

    // (px - cx) mod SCREEN_W < CAR_W, so a car straddling the right edge
    // also covers the leftmost columns.
    function automatic logic in_car(input logic [9:0] px, input logic [9:0] cx);
        logic signed [10:0] diff;
        diff = $signed({1'b0, px}) - $signed({1'b0, cx});
        if (diff < 11'sd0) begin
            diff = diff + $signed(11'(SCREEN_W));
        end
        return diff < $signed(11'(CAR_W));
    endfunction

    logic [3:0] sync_a;
    logic [3:0] sync_b;
    logic [3:0] sync_c;
    logic [3:0] fall;
    logic [3:0] pending;

    logic [4:0] fx;
    logic [3:0] fy;
    logic [4:0] fx_next;
    logic [3:0] fy_next;
    logic [7:0] score_next;
    logic [9:0] fx_px;
    logic       hit;

    logic [9:0]  car_x    [4];
    logic [9:0]  car_next [4];
    logic [10:0] car_sum  [4];

    logic       tick_now;
    logic [4:0] tile_row;
    logic [4:0] tile_col;
    logic [7:0] pixel;

    assign fall     = sync_c & ~sync_b;
    assign tick_now = (next_x == 10'd0) && (next_y == 10'(SCREEN_H));
    assign fx_px    = {fx, 5'd0};
    assign tile_row = next_y[9:5];
    assign tile_col = next_x[9:5];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            car_sum[i] = {1'b0, car_x[i]} + {1'b0, LANE_SPD[i]};
            if (car_sum[i] >= 11'(SCREEN_W)) begin
                car_next[i] = 10'(car_sum[i] - 11'(SCREEN_W));
            end else begin
                car_next[i] = car_sum[i][9:0];
            end
        end
    end

    // Hit beats goal beats move; all decisions use pre-tick register values.
    always_comb begin
        hit        = 1'b0;
        fx_next    = fx;
        fy_next    = fy;
        score_next = score;
        for (int i = 0; i < 4; i++) begin
            if (fy == LANE_ROW[i] &&
                (in_car(fx_px, car_x[i]) || in_car(fx_px + 10'd31, car_x[i]))) begin
                hit = 1'b1;
            end
        end
        if (hit) begin
            fx_next = START_X;
            fy_next = START_Y;
        end else if (fy == 4'd0) begin
            if (score != 8'hFF) begin
                score_next = score + 8'd1;
            end
            fx_next = START_X;
            fy_next = START_Y;
        end else if (pending[3]) begin
            fy_next = fy - 4'd1;
        end else if (pending[2]) begin
            if (fy != MAX_Y) fy_next = fy + 4'd1;
        end else if (pending[1]) begin
            if (fx != 5'd0) fx_next = fx - 5'd1;
        end else if (pending[0]) begin
            if (fx != MAX_X) fx_next = fx + 5'd1;
        end
    end

    always_comb begin
        pixel = 8'h00;
        if (next_x < 10'(SCREEN_W) && next_y < 10'(SCREEN_H)) begin
            pixel = (tile_row == 5'd0 || tile_row == 5'd14) ? GREEN : GREY;
            for (int i = 0; i < 4; i++) begin
                if (tile_row == {1'b0, LANE_ROW[i]} && in_car(next_x, car_x[i])) begin
                    pixel = RED;
                end
            end
            if (tile_col == fx && tile_row == {1'b0, fy}) begin
                pixel = YELLOW;
            end
        end
    end

    // Game state moves only in the frame_tick cycle, which falls in vertical
    // blanking; an edge seen in that same cycle survives into the next frame.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_a     <= 4'hF;
            sync_b     <= 4'hF;
            sync_c     <= 4'hF;
            pending    <= 4'h0;
            frame_tick <= 1'b0;
            color_in   <= 8'h00;
            score      <= 8'h00;
            fx         <= START_X;
            fy         <= START_Y;
            for (int i = 0; i < 4; i++) begin
                car_x[i] <= LANE_X0[i];
            end
        end else begin
            sync_a     <= btn_n;
            sync_b     <= sync_a;
            sync_c     <= sync_b;
            frame_tick <= tick_now;
            color_in   <= pixel;
            if (frame_tick) begin
                pending <= fall;
                fx      <= fx_next;
                fy      <= fy_next;
                score   <= score_next;
                for (int i = 0; i < 4; i++) begin
                    car_x[i] <= car_next[i];
                end
            end else begin
                pending <= pending | fall;
            end
        end
    end

endmodule

// File: tb/tb_frog_scene_renderer.sv
// Directed bench for frog_scene_renderer: pixel probes, moves, car wrap,
// collision, goal and score saturation.
module tb_frog_scene_renderer;

    localparam logic [7:0] YELLOW = 8'b11111100;
    localparam logic [7:0] RED    = 8'b11100000;
    localparam logic [7:0] GREEN  = 8'b00011100;
    localparam logic [7:0] GREY   = 8'b01001001;

    localparam int ROW [4] = '{3, 6, 9, 12};
    localparam int X0  [4] = '{0, 160, 320, 480};
    localparam int SPD [4] = '{1, 2, 3, 4};

    logic       clock = 1'b0;
    logic       reset;
    logic [9:0] next_x;
    logic [9:0] next_y;
    logic [3:0] btn_n;
    logic [7:0] color_in;
    logic [7:0] score;
    logic       frame_tick;

    int checks = 0;
    int errors = 0;

    // Reference model of the game state
    int         mfx, mfy, mscore, mgoals;
    int         mcar [4];
    logic [3:0] mpend;

    frog_scene_renderer dut (
        .clock      (clock),
        .reset      (reset),
        .next_x     (next_x),
        .next_y     (next_y),
        .btn_n      (btn_n),
        .color_in   (color_in),
        .score      (score),
        .frame_tick (frame_tick)
    );

    always #20 clock = ~clock;

    function automatic bit covers(input int px, input int cx);
        return ((px - cx + 640) % 640) < 64;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mfx    = 10;
        mfy    = 14;
        mscore = 0;
        mgoals = 0;
        mpend  = 4'h0;
        for (int i = 0; i < 4; i++) mcar[i] = X0[i];
    endtask

    task automatic model_tick();
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (mfy == ROW[i] && (covers(mfx * 32, mcar[i]) || covers(mfx * 32 + 31, mcar[i])))
                hit = 1'b1;
        end
        if (hit) begin
            mfx = 10;
            mfy = 14;
        end else if (mfy == 0) begin
            mgoals++;
            if (mscore < 255) mscore++;
            mfx = 10;
            mfy = 14;
        end else if (mpend[3]) begin
            if (mfy > 0) mfy--;
        end else if (mpend[2]) begin
            if (mfy < 14) mfy++;
        end else if (mpend[1]) begin
            if (mfx > 0) mfx--;
        end else if (mpend[0]) begin
            if (mfx < 19) mfx++;
        end
        for (int i = 0; i < 4; i++) mcar[i] = (mcar[i] + SPD[i]) % 640;
        mpend = 4'h0;
    endtask

    task automatic do_tick();
        @(negedge clock);
        next_x = 10'd0;
        next_y = 10'd480;
        @(negedge clock);
        check("frame_tick_high", {7'b0, frame_tick}, 8'd1);
        next_x = 10'd1;
        next_y = 10'd0;
        @(negedge clock);
        check("frame_tick_low", {7'b0, frame_tick}, 8'd0);
        model_tick();
    endtask

    task automatic press(input logic [3:0] mask);
        @(negedge clock);
        btn_n = ~mask;
        @(negedge clock);
        btn_n = 4'hF;
        @(negedge clock);
        mpend = mpend | mask;
    endtask

    task automatic probe(input string tag, input int x, input int y, input logic [7:0] exp);
        @(negedge clock);
        next_x = 10'(x);
        next_y = 10'(y);
        @(negedge clock);
        check(tag, color_in, exp);
    endtask

    initial begin
        int iter;
        bit unsafe;

        reset  = 1'b0;
        btn_n  = 4'hF;
        next_x = 10'd0;
        next_y = 10'd0;
        model_reset();
        repeat (3) @(negedge clock);
        check("reset_color", color_in, 8'h00);
        check("reset_score", score, 8'h00);
        check("reset_tick", {7'b0, frame_tick}, 8'd0);
        reset = 1'b1;

        probe("draw_goal_row", 0, 0, GREEN);
        probe("draw_frog_start", 320, 448, YELLOW);
        probe("draw_grey", 100, 200, GREY);
        probe("draw_car_row6", 170, 200, RED);
        probe("draw_offscreen_x", 700, 10, 8'h00);
        probe("draw_offscreen_y", 10, 500, 8'h00);

        // Up once, then 20 rights: fx clamps at 19
        press(4'b1000);
        do_tick();
        probe("up_move_frog", 320, 416, YELLOW);
        probe("up_move_start_empty", 320, 448, GREEN);
        check("score_after_move", score, 8'd0);
        for (int k = 0; k < 20; k++) begin
            press(4'b0001);
            do_tick();
        end
        probe("right_clamp_frog", 624, 432, YELLOW);
        probe("right_no_wrap", 16, 432, GREY);
        probe("right_clamp_prev", 592, 432, GREY);

        // Held left across three ticks moves once
        @(negedge clock);
        btn_n = 4'b1101;
        repeat (3) @(negedge clock);
        mpend = mpend | 4'b0010;
        repeat (3) do_tick();
        @(negedge clock);
        btn_n = 4'hF;
        probe("held_left_frog", 592, 432, YELLOW);
        probe("held_left_old", 624, 432, GREY);
        probe("held_left_once", 560, 432, GREY);

        // Down and left together: down wins, left is dropped
        press(4'b0110);
        do_tick();
        do_tick();
        probe("prio_down_frog", 592, 464, YELLOW);
        probe("prio_left_dropped", 560, 464, GREEN);

        // 30 ticks: row-12 car at 600 wraps over the right edge
        repeat (4) do_tick();
        probe("wrap600_left", 10, 400, RED);
        probe("wrap600_past", 30, 400, GREY);
        probe("wrap600_before", 599, 400, GREY);
        probe("wrap600_start", 600, 400, RED);
        // 40 ticks: row-12 car back at 0
        repeat (10) do_tick();
        probe("wrap0_first", 10, 400, RED);
        probe("wrap0_last", 63, 400, RED);
        probe("wrap0_after", 64, 400, GREY);
        probe("wrap0_right", 639, 400, GREY);

        // Asynchronous reset in the middle of a cycle
        @(negedge clock);
        #5 reset = 1'b0;
        #1;
        check("midreset_color", color_in, 8'h00);
        check("midreset_score", score, 8'h00);
        check("midreset_tick", {7'b0, frame_tick}, 8'd0);
        model_reset();
        @(negedge clock);
        reset = 1'b1;
        probe("midreset_frog", 320, 448, YELLOW);
        probe("midreset_car12", 490, 400, RED);
        probe("midreset_car12_edge", 470, 400, GREY);
        probe("midreset_old_frog", 592, 464, GREEN);

        // Walk to (0,3); the row-3 car (x=21) covers the right edge at tick 22
        repeat (10) begin
            press(4'b0010);
            do_tick();
        end
        repeat (11) begin
            press(4'b1000);
            do_tick();
        end
        probe("frog_in_lane3", 16, 112, YELLOW);
        do_tick();
        probe("hit_frog_gone", 16, 112, GREY);
        probe("hit_frog_start", 336, 464, YELLOW);
        check("hit_score_kept", score, 8'd0);

        // Straight up column 10 to the goal row
        repeat (14) begin
            press(4'b1000);
            do_tick();
        end
        probe("goal_row_frog", 336, 16, YELLOW);
        check("goal_score_before", score, 8'd0);
        do_tick();
        check("goal_score_after", score, 8'd1);
        probe("goal_frog_start", 336, 464, YELLOW);
        probe("goal_row_empty", 336, 16, GREEN);

        // Repeat goals until 256 total; wait out cars before entering a lane
        iter = 0;
        while (mgoals < 256 && iter < 20000) begin
            iter++;
            if (mfy == 0) begin
                do_tick();
                check("sat_goal_score", score, 8'(mscore));
            end else begin
                unsafe = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    if (ROW[i] == mfy - 1 &&
                        (covers(mfx * 32, (mcar[i] + SPD[i]) % 640) ||
                         covers(mfx * 32 + 31, (mcar[i] + SPD[i]) % 640)))
                        unsafe = 1'b1;
                end
                if (!unsafe) press(4'b1000);
                do_tick();
            end
        end
        checks++;
        assert (mgoals >= 256) else begin
            errors++;
            $error("FAIL sat_loop_bound: goals %0d required 256", mgoals);
        end
        check("score_saturated", score, 8'd255);
        probe("sat_frog_start", 336, 464, YELLOW);

        @(negedge clock);
        #5 reset = 1'b0;
        #1;
        check("reset_clears_score", score, 8'h00);
        @(negedge clock);
        reset = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
